// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//
// Pipelined RISC-V immediate generator sitting between decode and execute.
// Extracts and extends the I/S/B/U/J, CSR-zimm and shift-amount immediates
// to XLEN bits, computes the PC-relative target pc + imm, and registers the
// result behind a valid/ready handshake. Select 3'b111 is illegal: the entry
// still flows through with imm = 0, target = pc and the illegal flag set, and
// a saturating counter tracks how many such entries were accepted.
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   CNT_W  width of the illegal-select counter
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     input entry present
//   in_ready     block accepts the entry this cycle
//   in_instr     raw 32-bit instruction word
//   in_imm_sel   immediate format select
//   in_pc        PC of the instruction
//   out_valid    output entry present
//   out_ready    consumer accepts the output entry
//   out_imm      extended immediate
//   out_target   in_pc + imm, modulo 2^XLEN
//   out_illegal  entry carried the illegal select
//   illegal_cnt  saturating count of accepted illegal entries
//
// Build option:
//   IMM_GEN_SKID_EN  when defined, a one-entry skid register sits behind the
//                    output register and in_ready becomes a registered
//                    signal (capacity 2). When undefined there is a single
//                    output register and in_ready is combinational from
//                    out_ready (capacity 1).
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_sel,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  typedef enum logic [2:0] {
    SEL_I   = 3'b000,
    SEL_S   = 3'b001,
    SEL_B   = 3'b010,
    SEL_U   = 3'b011,
    SEL_J   = 3'b100,
    SEL_Z   = 3'b101,
    SEL_SH  = 3'b110,
    SEL_BAD = 3'b111
  } imm_sel_e;

  imm_sel_e        sel;
  logic [31:0]     imm32;
  logic [XLEN-1:0] new_imm;
  logic [XLEN-1:0] new_target;
  logic            new_illegal;
  logic            accept;
  logic            out_free;
  logic            unused_opcode;

  // The opcode field never contributes to any immediate.
  assign unused_opcode = ^in_instr[6:0];

  assign sel = imm_sel_e'(in_imm_sel);

  // Every format is first assembled as a 32-bit value that is already
  // correctly sign- or zero-extended to 32 bits; widening to XLEN is then a
  // plain sign extension for all formats (Z and SH have bit 31 clear, and U
  // is sign-extended above bit 31 on RV64).
  always_comb begin
    imm32       = '0;
    new_illegal = 1'b0;
    case (sel)
      SEL_I:  imm32 = {{21{in_instr[31]}}, in_instr[30:20]};
      SEL_S:  imm32 = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
      SEL_B:  imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
      SEL_U:  imm32 = {in_instr[31:12], 12'b0};
      SEL_J:  imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                       in_instr[30:21], 1'b0};
      SEL_Z:  imm32 = {27'b0, in_instr[19:15]};
      SEL_SH: imm32 = (XLEN == 64) ? {26'b0, in_instr[25:20]}
                                   : {27'b0, in_instr[24:20]};
      default: begin
        imm32       = '0;
        new_illegal = 1'b1;
      end
    endcase
  end

  // With imm forced to zero on an illegal select the adder output is
  // exactly the PC, so no separate bypass is needed.
  assign new_imm    = XLEN'($signed(imm32));
  assign new_target = in_pc + new_imm;

  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

`ifdef IMM_GEN_SKID_EN
  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  logic [XLEN-1:0] skid_target;
  logic            skid_illegal;

  // Ready depends only on the skid register, so there is no path from
  // out_ready; the skid is always empty when an entry is accepted.
  assign in_ready = !rst && !skid_valid;

  // Output register plus skid. When the output frees up, the skid entry
  // (older) is promoted first; otherwise a fresh entry loads straight into
  // the output. A fresh entry arriving while the output is stalled parks in
  // the skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_target   <= '0;
      out_illegal  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_target  <= '0;
      skid_illegal <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid   <= 1'b1;
        out_imm     <= skid_imm;
        out_target  <= skid_target;
        out_illegal <= skid_illegal;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_imm     <= new_imm;
        out_target  <= new_target;
        out_illegal <= new_illegal;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid   <= 1'b1;
      skid_imm     <= new_imm;
      skid_target  <= new_target;
      skid_illegal <= new_illegal;
    end
  end
`else
  assign in_ready = !rst && out_free;

  // Single output register: load on accept (which covers the
  // deliver-and-accept case with no bubble), empty on a plain deliver.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_target  <= '0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_imm     <= new_imm;
      out_target  <= new_target;
      out_illegal <= new_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  // Saturating count of accepted illegal entries; reset takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (accept && new_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the RISC-V datapath, sitting between instruction decode and the execute stage. It extracts and extends the immediate for I/S/B/U/J formats plus CSR-zimm and shift-amount forms, to a configurable XLEN. It also computes the PC-relative target `pc + imm`. Transfers use a valid/ready handshake with one registered stage, an optional skid buffer, and a saturating illegal-select counter.

## Interface
- `XLEN`, 32: datapath width; only 32 or 64 is legal.
- `CNT_W`, 8: width of the illegal-select counter.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input entry present.
- `in_ready` out 1: block accepts the entry this cycle.
- `in_instr` in 32: raw instruction word.
- `in_imm_sel` in 3: format select from the control unit.
- `in_pc` in XLEN: PC of the instruction.
- `out_valid` out 1: output entry present.
- `out_ready` in 1: consumer accepts the output entry.
- `out_imm` out XLEN: extended immediate.
- `out_target` out XLEN: `in_pc + imm`, modulo 2^XLEN.
- `out_illegal` out 1: entry had an illegal select.
- `illegal_cnt` out CNT_W: count of accepted illegal entries, saturating.

## Operation
- Select encodings (s = `in_instr[31]`, sign-extended to XLEN):
  - 000 I: s, instr[30:20].
  - 001 S: s, instr[30:25], instr[11:7].
  - 010 B: s, instr[7], instr[30:25], instr[11:8], 0.
  - 011 U: instr[31:12], twelve zero bits; sign-extended above bit 31 when XLEN=64.
  - 100 J: s, instr[19:12], instr[20], instr[30:21], 0.
  - 101 Z: instr[19:15] zero-extended.
  - 110 SH: instr[24:20] zero-extended when XLEN=32; instr[25:20] when XLEN=64.
  - 111: illegal; `out_imm`=0, `out_target`=`in_pc`, `out_illegal`=1.
- Accept: `in_valid && in_ready`. Deliver: `out_valid && out_ready`.
- Immediate, target and illegal flag are computed combinationally from the inputs and captured on accept.
- `illegal_cnt` increments on each accept with select 111 and holds at all-ones.
- Entries leave in acceptance order. No entry is dropped or duplicated.
- Output fields hold stable while `out_valid && !out_ready`.

## Timing
- Latency: an entry accepted at edge N is presented with `out_valid`=1 after edge N. It can be delivered in the cycle following edge N.
- Throughput: one entry per cycle while `out_ready`=1.
- While `rst` is high at an edge:
  - `out_valid`=0, `out_imm`=0, `out_target`=0, `out_illegal`=0, `illegal_cnt`=0.
  - `in_ready` is forced 0 during any cycle in which `rst` is high.
  - Skid buffer (when present) is emptied.
- Reset mid-operation discards all held entries. The first accept is possible in the first cycle with `rst` low.
- Simultaneous deliver and accept in one cycle: the output register reloads with the new entry, with no bubble.
- Counter saturation and a simultaneous reset: reset wins.

## Configuration
- `IMM_GEN_SKID_EN` defined:
  - Adds a one-entry skid register behind the output register.
  - `in_ready` is a registered signal: 1 when the skid buffer is empty, with no combinational path from `out_ready`.
  - An entry accepted while the output register is stalled goes to the skid buffer. `in_ready` drops on the next cycle.
  - When the output is delivered, the skid entry moves to the output register. `in_ready` returns to 1 on the following cycle.
  - Capacity is 2 entries.
- `IMM_GEN_SKID_EN` undefined:
  - Single output register.
  - `in_ready = !rst && (!out_valid || out_ready)`, which is combinational from `out_ready`.
  - Capacity is 1 entry.

## Test plan
- I-type, XLEN=32: `in_instr`=0xFFF00093, sel 000, `in_pc`=0x100 -> `out_imm`=0xFFFFFFFF, `out_target`=0x000000FF, `out_illegal`=0, one cycle after accept.
- B and J types, XLEN=32:
  - 0xFE000EE3, sel 010, pc 0x200 -> imm 0xFFFFFFFC, target 0x1FC.
  - 0x0010006F, sel 100, pc 0x1000 -> imm 0x800, target 0x1800.
- U, Z and SH types:
  - XLEN=64, 0x800000B7, sel 011 -> imm 0xFFFFFFFF80000000.
  - 0x000F8073, sel 101 -> imm 0x1F.
  - XLEN=64, 0x03F00013, sel 110 -> imm 0x3F.
- Backpressure: hold `out_ready`=0 and offer 3 back-to-back entries A, B, C.
  - With skid: A and B accepted, `in_ready` low from the following cycle, C held.
  - Without skid: only A accepted.
  - Release `out_ready`: A, B, C delivered in order, each unchanged, none lost.
- Illegal counter, CNT_W=8: 300 accepted entries with sel 111 -> each has `out_imm`=0, `out_target`=pc, `out_illegal`=1; `illegal_cnt` ends at 255.
- Reset mid-stream: assert `rst` for one cycle while 2 entries are held and `illegal_cnt`=5 -> next cycle `out_valid`=0, `illegal_cnt`=0, skid buffer empty. The first post-reset entry is delivered with 1-cycle latency.
